// File: rtl/data_memory_lsu_if.sv
// Load/store bus between the datapath and data_memory_lsu.
// Request side : ALUResult (byte address), WriteData (rs2), MemWrite, MemRead, funct3.
// Response side: ReadData, MisalignedErr (combinational), ErrSticky, ErrAddr,
//                StoreCount (registered debug state).
// master = datapath / testbench driving requests, slave = the LSU.
interface data_memory_lsu_if;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  funct3;
    logic [31:0] ReadData;
    logic        MisalignedErr;
    logic        ErrSticky;
    logic [31:0] ErrAddr;
    logic [15:0] StoreCount;

    modport master (
        output ALUResult, WriteData, MemWrite, MemRead, funct3,
        input  ReadData, MisalignedErr, ErrSticky, ErrAddr, StoreCount
    );

    modport slave (
        input  ALUResult, WriteData, MemWrite, MemRead, funct3,
        output ReadData, MisalignedErr, ErrSticky, ErrAddr, StoreCount
    );
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: RV32I data memory with byte/half/word load/store.
// Ports:
//   clk   - single clock, all state updates on posedge
//   reset - synchronous, active-high; zeroes the array and debug registers
//   bus   - data_memory_lsu_if.slave: address/data/control in, load data,
//           error flag and debug registers out
// Loads are zero-latency reads of the array. Stores commit on posedge unless
// the access is misaligned or uses an illegal funct3. A sticky error flag with
// the first faulting address and a saturating committed-store counter are kept.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_lsu_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NUM_LANES = 4;

    // Word array held as byte lanes so stores can merge per lane.
    logic [NUM_LANES-1:0][7:0] mem_q [DEPTH_WORDS];
    logic [NUM_LANES-1:0][7:0] mem_d [DEPTH_WORDS];

    logic        err_sticky_q, err_sticky_d;
    logic [31:0] err_addr_q,   err_addr_d;
    logic [15:0] store_cnt_q,  store_cnt_d;

    logic [AW-1:0]             idx;
    logic [1:0]                lane;
    logic [NUM_LANES-1:0][7:0] rd_word;
    logic [7:0]                rd_byte;
    logic [15:0]               rd_half;
    logic [31:0]               load_val;
    logic                      access;
    logic                      load_f3_ok;
    logic                      store_f3_ok;
    logic                      misalign;
    logic                      err;
    logic                      commit;
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] wbytes;

    // Upper address bits alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ALUResult[31:AW+2];

    assign idx    = bus.ALUResult[AW+1:2];
    assign lane   = bus.ALUResult[1:0];
    assign access = bus.MemRead | bus.MemWrite;

    // Error detection
    always_comb begin
        load_f3_ok  = 1'b0;
        store_f3_ok = 1'b0;
        misalign    = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: load_f3_ok = 1'b1;
            3'b001, 3'b101: load_f3_ok = 1'b1;
            3'b010:         load_f3_ok = 1'b1;
            default:        load_f3_ok = 1'b0;
        endcase
        store_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010);
        // Width comes from funct3[1:0]; illegal codes are caught by the f3 checks.
        if (bus.funct3[1:0] == 2'b01 && lane[0])
            misalign = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && lane != 2'b00)
            misalign = 1'b1;
    end

    assign err = access & (misalign | (bus.MemRead & ~load_f3_ok) |
                           (bus.MemWrite & ~store_f3_ok));
    assign commit = bus.MemWrite & ~err;

    // Load path: always shows pre-write contents of the addressed word.
    always_comb begin
        rd_word  = mem_q[idx];
        rd_byte  = rd_word[lane];
        rd_half  = lane[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
        load_val = '0;
        case (bus.funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = '0;
        endcase
    end

    assign bus.ReadData      = (bus.MemRead & ~err) ? load_val : 32'd0;
    assign bus.MisalignedErr = err;

    // Store lane enables; data is replicated across lanes and masked by be.
    always_comb begin
        be     = '0;
        wbytes = bus.WriteData;
        case (bus.funct3)
            3'b000: begin
                be     = 4'b0001 << lane;
                wbytes = {4{bus.WriteData[7:0]}};
            end
            3'b001: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wbytes = {2{bus.WriteData[15:0]}};
            end
            3'b010:  be = 4'b1111;
            default: be = '0;
        endcase
    end

    // Next-state
    always_comb begin
        for (int w = 0; w < DEPTH_WORDS; w++)
            mem_d[w] = mem_q[w];
        if (commit) begin
            for (int l = 0; l < NUM_LANES; l++)
                if (be[l])
                    mem_d[idx][l] = wbytes[l];
        end

        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        // Only the first error since reset records its address.
        if (err && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = bus.ALUResult;
        end

        store_cnt_d = store_cnt_q;
        if (commit && store_cnt_q != 16'hFFFF)
            store_cnt_d = store_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < DEPTH_WORDS; w++)
                mem_q[w] <= '0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            for (int w = 0; w < DEPTH_WORDS; w++)
                mem_q[w] <= mem_d[w];
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign bus.ErrSticky  = err_sticky_q;
    assign bus.ErrAddr    = err_addr_q;
    assign bus.StoreCount = store_cnt_q;
endmodule
